// File: rtl/bram_dual_be_client.sv
// bram_dual_be_client
//
// Initiator for an external dual-port byte-enable block RAM (one read port,
// one write port, one-cycle read latency). Client logic sees three streams:
// read requests, write requests and read responses. Read data is captured
// into a small response FIFO so the client can apply back-pressure without
// stalling the RAM pipeline.
//
// Handshake semantics (all three streams): a transfer happens on a rising
// CLK edge where valid && ready are both 1. A source holds valid and its
// payload stable until the transfer. ready may depend combinationally on
// the current cycle's inputs only where stated below.
//
// Ports
//   CLK, RST            clock (posedge) and synchronous active-high reset
//   rd_req_valid/ready  read request stream, payload rd_req_addr
//                       (ready depends on registered state only)
//   wr_req_valid/ready  write request stream, payload wr_req_addr/data/be
//                       (ready falls combinationally when a same-cycle read
//                       to the same address fires)
//   rd_rsp_valid/ready  read response stream, payload rd_rsp_data, returned
//                       in request order two cycles after the read fires
//   ram_*               direct RAM pins; ram_do is valid the cycle after ram_re
//
// RSP_DEPTH must be >= 2; a depth of 3 sustains one read per cycle.

module bram_dual_be_client #(
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 8,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int RSP_DEPTH  = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  // read request
  input  logic                  rd_req_valid,
  output logic                  rd_req_ready,
  input  logic [ADDR_WIDTH-1:0] rd_req_addr,
  // write request
  input  logic                  wr_req_valid,
  output logic                  wr_req_ready,
  input  logic [ADDR_WIDTH-1:0] wr_req_addr,
  input  logic [DATA_WIDTH-1:0] wr_req_data,
  input  logic [BE_WIDTH-1:0]   wr_req_be,
  // read response
  output logic                  rd_rsp_valid,
  input  logic                  rd_rsp_ready,
  output logic [DATA_WIDTH-1:0] rd_rsp_data,
  // RAM pins
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  output logic                  ram_re,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic                  ram_we,
  output logic [BE_WIDTH-1:0]   ram_be,
  output logic [DATA_WIDTH-1:0] ram_di,
  input  logic [DATA_WIDTH-1:0] ram_do
);

  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(RSP_DEPTH - 1);
  localparam logic [CNT_W:0]   DEPTH_EXT = (CNT_W + 1)'(RSP_DEPTH);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic                  inflight_q, inflight_d;
  logic [PTR_W-1:0]      wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q,   rd_ptr_d;
  logic [CNT_W-1:0]      count_q,    count_d;
  logic [DATA_WIDTH-1:0] mem_q [RSP_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [RSP_DEPTH];

  // ---------------------------------------------------------------------
  // Combinational issue / response logic
  // ---------------------------------------------------------------------
  logic           rd_fire;
  logic           wr_fire;
  logic           collide;
  logic           push;
  logic           pop;
  logic [CNT_W:0] occupancy;

  always_comb begin
    // A read slot is granted only if the FIFO can absorb every response
    // already owed (queued + the one on the RAM output) plus this one.
    // Using registered state only keeps rd_rsp_ready off this path.
    occupancy    = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    rd_req_ready = (occupancy < DEPTH_EXT);
    rd_fire      = rd_req_valid && rd_req_ready;

    // The RAM returns X on a same-address read/write in one cycle. The
    // read wins; the write is held off one cycle, so the read observes
    // pre-write data.
    collide      = rd_fire && (rd_req_addr == wr_req_addr);
    wr_req_ready = !collide;
    wr_fire      = wr_req_valid && wr_req_ready;

    // RAM pins. ram_re stays low when idle so ram_do holds its value.
    ram_re       = rd_fire;
    ram_rd_addr  = rd_req_addr;
    ram_we       = wr_fire;
    ram_wr_addr  = wr_req_addr;
    ram_be       = wr_req_be;
    ram_di       = wr_req_data;

    // Response FIFO interface
    rd_rsp_valid = (count_q != '0);
    rd_rsp_data  = mem_q[rd_ptr_q];
    push         = inflight_q;
    pop          = rd_rsp_valid && rd_rsp_ready;
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    inflight_d = rd_fire;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    mem_d      = mem_q;

    // Push is legal even when full: the accounting guarantees a full FIFO
    // with a read in flight cannot happen unless a pop frees the slot.
    if (push) begin
      mem_d[wr_ptr_q] = ram_do;
      wr_ptr_d        = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end

    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  // Control state: reset discards any in-flight read and queued responses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage carries no reset; entries are only visible once counted.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_bram_dual_be_client.sv
// Testbench for bram_dual_be_client with a behavioural dual-port byte-enable
// RAM (returns X on a same-address read/write collision) and a shadow memory
// that predicts read data.

module tb_bram_dual_be_client;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int BW    = 4;
  localparam int DEPTH = 3;

  // ---------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------
  logic CLK;
  logic RST;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------------------------------------------------------------
  // DUT
  // ---------------------------------------------------------------------
  logic          rd_req_valid, rd_req_ready;
  logic [AW-1:0] rd_req_addr;
  logic          wr_req_valid, wr_req_ready;
  logic [AW-1:0] wr_req_addr;
  logic [DW-1:0] wr_req_data;
  logic [BW-1:0] wr_req_be;
  logic          rd_rsp_valid, rd_rsp_ready;
  logic [DW-1:0] rd_rsp_data;
  logic [AW-1:0] ram_rd_addr, ram_wr_addr;
  logic          ram_re, ram_we;
  logic [BW-1:0] ram_be;
  logic [DW-1:0] ram_di, ram_do;

  bram_dual_be_client #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .BE_WIDTH   (BW),
    .RSP_DEPTH  (DEPTH)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_req_addr  (rd_req_addr),
    .wr_req_valid (wr_req_valid),
    .wr_req_ready (wr_req_ready),
    .wr_req_addr  (wr_req_addr),
    .wr_req_data  (wr_req_data),
    .wr_req_be    (wr_req_be),
    .rd_rsp_valid (rd_rsp_valid),
    .rd_rsp_ready (rd_rsp_ready),
    .rd_rsp_data  (rd_rsp_data),
    .ram_rd_addr  (ram_rd_addr),
    .ram_re       (ram_re),
    .ram_wr_addr  (ram_wr_addr),
    .ram_we       (ram_we),
    .ram_be       (ram_be),
    .ram_di       (ram_di),
    .ram_do       (ram_do)
  );

  // ---------------------------------------------------------------------
  // RAM model
  // ---------------------------------------------------------------------
  logic [DW-1:0] ram_mem [16];

  always @(posedge CLK) begin
    if (ram_re) begin
      if (ram_we && (ram_wr_addr == ram_rd_addr)) ram_do <= {DW{1'bx}};
      else                                        ram_do <= ram_mem[ram_rd_addr];
    end
    if (ram_we) begin
      for (int b = 0; b < BW; b++) begin
        if (ram_be[b]) ram_mem[ram_wr_addr][8*b +: 8] <= ram_di[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] shadow [16];
  int            checks    = 0;
  int            errors    = 0;
  int            rsp_count = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                          input logic [DW-1:0] d,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old_w;
    for (int b = 0; b < BW; b++) begin
      if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    end
    return r;
  endfunction

  // Response monitor: pops one expectation per consumed response.
  always @(negedge CLK) begin
    if (!RST && rd_rsp_valid && rd_rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", {31'd0, rd_rsp_valid}, 32'd0);
      end else begin
        check("rsp_data", rd_rsp_data, exp_q.pop_front());
      end
      rsp_count++;
    end
  end

  // ---------------------------------------------------------------------
  // Driver tasks (entered and left at posedge + 1)
  // ---------------------------------------------------------------------
  logic rf, wf;

  task automatic step(input logic rv, input logic [AW-1:0] ra,
                      input logic wv, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd, input logic [BW-1:0] wbe,
                      output logic rfo, output logic wfo);
    rd_req_valid = rv;
    rd_req_addr  = ra;
    wr_req_valid = wv;
    wr_req_addr  = wa;
    wr_req_data  = wd;
    wr_req_be    = wbe;
    @(negedge CLK);
    rfo = rd_req_valid && rd_req_ready;
    wfo = wr_req_valid && wr_req_ready;
    if (!RST) begin
      if (rfo) exp_q.push_back(shadow[ra]);
      if (wfo) shadow[wa] = merge(shadow[wa], wd, wbe);
    end
    @(posedge CLK);
    #1;
    rd_req_valid = 1'b0;
    wr_req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    logic a, b;
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, '0, '0, a, b);
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
    logic a_f, w_f;
    step(1'b0, '0, 1'b1, a, d, be, a_f, w_f);
    check("write_accept", {31'd0, w_f}, 32'd1);
  endtask

  task automatic read_word(input logic [AW-1:0] a);
    logic r_f, w_f;
    int   tries;
    tries = 0;
    r_f   = 1'b0;
    while (!r_f && tries < 20) begin
      step(1'b1, a, 1'b0, '0, '0, '0, r_f, w_f);
      tries++;
    end
    check("read_accept", {31'd0, r_f}, 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0) && n < 50) begin
      idle(1);
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------
  int base;
  int rd_fires, wr_fires;

  initial begin
    RST          = 1'b1;
    rd_req_valid = 1'b0;
    rd_req_addr  = '0;
    wr_req_valid = 1'b0;
    wr_req_addr  = '0;
    wr_req_data  = '0;
    wr_req_be    = '0;
    rd_rsp_ready = 1'b0;
    for (int i = 0; i < 16; i++) shadow[i] = '0;

    // Reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_rsp_valid", {31'd0, rd_rsp_valid}, 32'd0);
    check("rst_rd_ready",  {31'd0, rd_req_ready}, 32'd1);
    check("rst_wr_ready",  {31'd0, wr_req_ready}, 32'd1);
    check("rst_ram_re",    {31'd0, ram_re},       32'd0);
    check("rst_ram_we",    {31'd0, ram_we},       32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;

    // Known RAM contents
    for (int a = 0; a < 16; a++) write_word(AW'(a), 32'd0, 4'hF);

    // 1. Write then read, 2-cycle latency
    write_word(4'd5, 32'hA1B2C3D4, 4'hF);
    step(1'b1, 4'd5, 1'b0, '0, '0, '0, rf, wf);
    check("t1_rd_fire", {31'd0, rf}, 32'd1);
    @(negedge CLK);
    check("t1_lat1_valid", {31'd0, rd_rsp_valid}, 32'd0);
    @(posedge CLK);
    #1;
    @(negedge CLK);
    check("t1_lat2_valid", {31'd0, rd_rsp_valid}, 32'd1);
    check("t1_lat2_data",  rd_rsp_data, 32'hA1B2C3D4);
    @(posedge CLK);
    #1;
    rd_rsp_ready = 1'b1;
    drain();

    // 2. Byte merge
    write_word(4'd2, 32'h11223344, 4'hF);
    write_word(4'd2, 32'hAABBCCDD, 4'b0101);
    read_word(4'd2);
    drain();

    // 3. Collision: read wins, write lands the cycle after
    write_word(4'd7, 32'h00000001, 4'hF);
    step(1'b1, 4'd7, 1'b1, 4'd7, 32'hFFFFFFFF, 4'hF, rf, wf);
    check("t3_rd_fire",       {31'd0, rf}, 32'd1);
    check("t3_collide_stall", {31'd0, wf}, 32'd0);
    write_word(4'd7, 32'hFFFFFFFF, 4'hF);
    read_word(4'd7);
    drain();

    // 4. Back-pressure
    for (int a = 0; a < 10; a++) write_word(AW'(a), 32'hC0DE0000 | 32'(a * 16'h0101), 4'hF);
    rd_rsp_ready = 1'b0;
    base = rsp_count;
    for (int a = 0; a < 3; a++) begin
      step(1'b1, AW'(a), 1'b0, '0, '0, '0, rf, wf);
      check("t4_accept", {31'd0, rf}, 32'd1);
    end
    step(1'b1, 4'd3, 1'b0, '0, '0, '0, rf, wf);
    check("t4_ready_low_a", {31'd0, rf}, 32'd0);
    step(1'b1, 4'd3, 1'b0, '0, '0, '0, rf, wf);
    check("t4_ready_low_b", {31'd0, rf}, 32'd0);
    rd_rsp_ready = 1'b1;
    for (int a = 3; a < 10; a++) read_word(AW'(a));
    drain();
    check("t4_rsp_count", 32'(rsp_count - base), 32'd10);

    // 5. Throughput: one read and one disjoint write every cycle
    rd_fires = 0;
    wr_fires = 0;
    for (int i = 0; i < 100; i++) begin
      step(1'b1, AW'(i % 8), 1'b1, AW'(8 + (i % 8)), $urandom, BW'($urandom_range(0, 15)), rf, wf);
      rd_fires += int'(rf);
      wr_fires += int'(wf);
    end
    check("t5_rd_fires", 32'(rd_fires), 32'd100);
    check("t5_wr_fires", 32'(wr_fires), 32'd100);
    drain();
    for (int a = 8; a < 16; a++) read_word(AW'(a));
    drain();

    // 6. Reset with two reads in flight
    rd_rsp_ready = 1'b0;
    step(1'b1, 4'd1, 1'b0, '0, '0, '0, rf, wf);
    step(1'b1, 4'd2, 1'b0, '0, '0, '0, rf, wf);
    RST = 1'b1;
    exp_q.delete();
    idle(1);
    @(negedge CLK);
    check("t6_rsp_valid_after_rst", {31'd0, rd_rsp_valid}, 32'd0);
    check("t6_rd_ready_after_rst",  {31'd0, rd_req_ready}, 32'd1);
    @(posedge CLK);
    #1;
    RST          = 1'b0;
    rd_rsp_ready = 1'b1;
    base         = rsp_count;
    idle(8);
    check("t6_no_stale", 32'(rsp_count - base), 32'd0);

    // Post-reset sanity read
    read_word(4'd5);
    drain();

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net against a hung run
  initial begin
    #200000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
